// File: rtl/mem_burst_pkg.sv
// Shared types and default sizing for the memory burst master.
package mem_burst_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_burst_master_if.sv
// Command, write-stream, read-stream and memory-side signals of the burst master.
interface mem_burst_master_if #(
    parameter int WIDTH      = mem_burst_pkg::DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = $clog2(mem_burst_pkg::DEFAULT_DEPTH)
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH:0]   cmd_len;

    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic [WIDTH-1:0]      wr_data;

    logic                  rd_data_valid;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_data_last;

    logic                  mem_valid;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ready;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_data_valid, wr_data,
        output wr_data_ready,
        output rd_data_valid, rd_data, rd_data_last,
        output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_data_valid, wr_data,
        input  wr_data_ready,
        input  rd_data_valid, rd_data, rd_data_last,
        input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_burst_addr_gen.sv
// Burst address (modulo DEPTH) and remaining-word counter; loads on accept, steps per word.
module mem_burst_addr_gen
    import mem_burst_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Explicit wrap keeps the sequence correct for non-power-of-two depths.
    assign addr_next = (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
    assign last      = (remaining == (ADDR_WIDTH + 1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= load_len;
        end else if (step) begin
            addr      <= addr_next;
            remaining <= remaining - (ADDR_WIDTH + 1)'(1);
        end
    end

endmodule

// File: rtl/mem_burst_master.sv
// Burst sequencer driving the single-port memory one word per handshake.
// Optional build macro MEM_BURST_LEN_CHECK_EN rejects out-of-range cmd_len and adds err.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    mem_burst_master_if.master bus,
    output logic busy,
    output logic done
`ifdef MEM_BURST_LEN_CHECK_EN
    ,
    output logic err
`endif
);

    state_t state, state_next;

    logic                  cmd_acc;
    logic                  wr_acc;
    logic                  mem_hs;
    logic                  len_skip;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] addr;

    logic                  wr_rd_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      rd_data_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;

    assign cmd_acc = bus.cmd_valid && (state == IDLE);
    assign wr_acc  = bus.wr_data_valid && (state == WAIT_DATA);
    assign mem_hs  = (state == ISSUE) && bus.mem_ready;

`ifdef MEM_BURST_LEN_CHECK_EN
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);
    assign len_skip = (bus.cmd_len == '0) || (bus.cmd_len > MAX_LEN);
`else
    assign len_skip = (bus.cmd_len == '0);
`endif

    mem_burst_addr_gen #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cmd_acc),
        .load_addr (bus.cmd_addr),
        .load_len  (bus.cmd_len),
        .step      (mem_hs),
        .addr      (addr),
        .last      (last_word)
    );

    // NOTE: reset lands in IDLE, so cmd_ready (decoded from state) reads 1 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (len_skip)        state_next = DONE;
                    else if (bus.cmd_wr) state_next = WAIT_DATA;
                    else                 state_next = ISSUE;
                end
            end
            WAIT_DATA: begin
                if (wr_acc) state_next = ISSUE;
            end
            ISSUE: begin
                if (mem_hs) begin
                    if (last_word)    state_next = DONE;
                    else if (wr_rd_q) state_next = WAIT_DATA;
                    else              state_next = ISSUE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rd_q    <= 1'b0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (cmd_acc) wr_rd_q <= bus.cmd_wr;
            if (wr_acc)  wdata_q <= bus.wr_data;
            rd_valid_q <= mem_hs && !wr_rd_q;
            rd_last_q  <= mem_hs && !wr_rd_q && last_word;
            if (mem_hs && !wr_rd_q) rd_data_q <= bus.mem_rdata;
        end
    end

`ifdef MEM_BURST_LEN_CHECK_EN
    logic err_q;

    // A rejected command still passes through DONE, which then reports err instead of done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (cmd_acc) err_q <= len_skip;
    end

    assign err  = (state == DONE) && err_q;
    assign done = (state == DONE) && !err_q;
`else
    assign done = (state == DONE);
`endif

    assign busy              = (state != IDLE);
    assign bus.cmd_ready     = (state == IDLE);
    assign bus.wr_data_ready = (state == WAIT_DATA);
    assign bus.mem_valid     = (state == ISSUE);
    assign bus.mem_wr_rd     = wr_rd_q;
    assign bus.mem_addr      = addr;
    assign bus.mem_wdata     = wdata_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_last  = rd_last_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural memory on the far side.
module tb_mem_burst_master;
    import mem_burst_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    logic done;
`ifdef MEM_BURST_LEN_CHECK_EN
    logic err;
    int   err_cnt;
    int   err_cyc;
`endif

    mem_burst_master_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    mem_burst_master #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
`ifdef MEM_BURST_LEN_CHECK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem_model [DEPTH];
    assign bus.mem_rdata = mem_model[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_valid && bus.mem_ready && bus.mem_wr_rd)
            mem_model[bus.mem_addr] <= bus.mem_wdata;
    end

    int total;
    int bad;

    int               cyc;
    int               acc_cyc;
    logic [AW-1:0]    hs_addr [$];
    logic             hs_wr [$];
    logic [WIDTH-1:0] hs_wdata [$];
    logic [WIDTH-1:0] rd_q [$];
    logic             rd_last_q [$];
    int               rd_cyc [$];
    int               done_cnt;
    int               done_cyc;
    int               valid_cnt;
    int               stall_cfg;
    int               stall_ctr;
    bit               wr_en;
    logic [WIDTH-1:0] wr_base;
    int               wr_idx;
    bit               chk_stall;
    logic [AW-1:0]    ref_addr;
    logic             ref_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        hs_addr.delete();
        hs_wr.delete();
        hs_wdata.delete();
        rd_q.delete();
        rd_last_q.delete();
        rd_cyc.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        valid_cnt = 0;
`ifdef MEM_BURST_LEN_CHECK_EN
        err_cnt = 0;
        err_cyc = 0;
`endif
    endtask

    task automatic set_wr_source(input bit en, input logic [WIDTH-1:0] base);
        wr_en             = en;
        wr_base           = base;
        wr_idx            = 0;
        bus.wr_data_valid = en;
        bus.wr_data       = base;
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic clk_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.rd_data_valid) begin
            rd_q.push_back(bus.rd_data);
            rd_last_q.push_back(bus.rd_data_last);
            rd_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
`ifdef MEM_BURST_LEN_CHECK_EN
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
`endif
        if (bus.mem_valid) valid_cnt++;

        bus.mem_ready = (stall_ctr >= stall_cfg);
        if (bus.mem_valid) begin
            if (chk_stall) begin
                if (stall_ctr == 0) begin
                    ref_addr = bus.mem_addr;
                    ref_wr   = bus.mem_wr_rd;
                end else begin
                    check("stall_addr_stable", bus.mem_addr, ref_addr);
                    check("stall_wr_rd_stable", bus.mem_wr_rd, ref_wr);
                end
            end
            if (bus.mem_ready) begin
                hs_addr.push_back(bus.mem_addr);
                hs_wr.push_back(bus.mem_wr_rd);
                hs_wdata.push_back(bus.mem_wdata);
                stall_ctr = 0;
            end else begin
                stall_ctr++;
            end
        end else begin
            stall_ctr = 0;
        end

        bus.wr_data_valid = wr_en;
        bus.wr_data       = wr_base + WIDTH'(wr_idx);
        if (bus.wr_data_valid && bus.wr_data_ready) wr_idx++;
    endtask

    task automatic send_cmd(input bit wr, input int addr, input int len);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            clk_step();
            guard++;
        end
        check("cmd_ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = (AW + 1)'(len);
        clk_step();
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_latency);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            clk_step();
            n++;
        end
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_done_latency"}, done_cyc - acc_cyc + 1, exp_latency);
        clk_step();
        check({tag, "_done_single"}, done_cnt, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_cmd_ready_after"}, bus.cmd_ready, 1);
    endtask

    task automatic check_hs(input string tag, input int start, input int len,
                            input bit wr, input logic [WIDTH-1:0] base);
        check({tag, "_hs_count"}, hs_addr.size(), len);
        for (int i = 0; i < len && i < hs_addr.size(); i++) begin
            check({tag, "_addr"}, hs_addr[i], (start + i) % DEPTH);
            check({tag, "_wr_rd"}, hs_wr[i], wr);
            if (wr) check({tag, "_wdata"}, hs_wdata[i], base + WIDTH'(i));
        end
    endtask

    task automatic check_rd(input string tag, input int len, input logic [WIDTH-1:0] base);
        check({tag, "_rd_count"}, rd_q.size(), len);
        for (int i = 0; i < len && i < rd_q.size(); i++) begin
            check({tag, "_rd_data"}, rd_q[i], base + WIDTH'(i));
            check({tag, "_rd_last"}, rd_last_q[i], (i == len - 1));
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.mem_ready = 1'b0;
        stall_cfg     = 0;
        stall_ctr     = 0;
        chk_stall     = 1'b0;
        set_wr_source(1'b0, '0);
        clear_logs();

        // Reset values, sampled while reset is still asserted
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_wr_rd", bus.mem_wr_rd, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_wr_data_ready", bus.wr_data_ready, 0);
        check("rst_rd_data_valid", bus.rd_data_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_data_last", bus.rd_data_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        clk_step();
        clk_step();
        rst_n = 1'b1;
        clk_step();

        // Full-depth write; mem_ready sits high while idle and must be ignored
        set_wr_source(1'b1, 16'h1000);
        clear_logs();
        clk_step();
        clk_step();
        check("idle_no_hs", hs_addr.size(), 0);
        send_cmd(1'b1, 0, 64);
        check("wr64_wr_ready_n1", bus.wr_data_ready, 1);
        check("wr64_mem_valid_n1", bus.mem_valid, 0);
        wait_done("wr64", 300, 129);
        check_hs("wr64", 0, 64, 1'b1, 16'h1000);

        // Full-depth read back, one word per cycle
        set_wr_source(1'b0, '0);
        clear_logs();
        send_cmd(1'b0, 0, 64);
        check("rd64_mem_valid_n1", bus.mem_valid, 1);
        wait_done("rd64", 300, 65);
        check_hs("rd64", 0, 64, 1'b0, '0);
        check_rd("rd64", 64, 16'h1000);
        if (rd_cyc.size() == 64) begin
            check("rd64_consecutive", rd_cyc[63] - rd_cyc[0], 63);
            check("rd64_last_with_done", rd_cyc[63], done_cyc);
        end

        // Write across the top of the address space
        set_wr_source(1'b1, 16'h2000);
        clear_logs();
        send_cmd(1'b1, 62, 4);
        wait_done("wrap", 100, 9);
        check_hs("wrap", 62, 4, 1'b1, 16'h2000);

        // Read with 5 stall cycles before each word
        set_wr_source(1'b0, '0);
        stall_cfg = 5;
        chk_stall = 1'b1;
        clear_logs();
        send_cmd(1'b0, 62, 3);
        wait_done("stall", 200, 19);
        check_hs("stall", 62, 3, 1'b0, '0);
        check_rd("stall", 3, 16'h2000);
        stall_cfg = 0;
        chk_stall = 1'b0;

        // Reset in the middle of a write burst, while the third word is on the bus
        set_wr_source(1'b1, 16'h3000);
        clear_logs();
        send_cmd(1'b1, 10, 8);
        for (int n = 0; n < 50 && hs_addr.size() < 3; n++) clk_step();
        check("rst_mid_reached", hs_addr.size(), 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_valid", bus.mem_valid, 0);
        check("rst_mid_cmd_ready", bus.cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        if (hs_addr.size() == 3) begin
            hs_addr.pop_back();
            hs_wr.pop_back();
            hs_wdata.pop_back();
        end
        valid_cnt = 0;
        clk_step();
        clk_step();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) clk_step();
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_no_rd", rd_q.size(), 0);
        check("rst_mid_no_valid", valid_cnt, 0);
        check_hs("rst_mid", 10, 2, 1'b1, 16'h3000);
        check("rst_mid_mem10", mem_model[10], 16'h3000);
        check("rst_mid_mem11", mem_model[11], 16'h3001);
        check("rst_mid_mem12", mem_model[12], 16'h100C);

        set_wr_source(1'b1, 16'h4000);
        clear_logs();
        send_cmd(1'b1, 5, 1);
        wait_done("post_rst_wr", 50, 3);
        check_hs("post_rst_wr", 5, 1, 1'b1, 16'h4000);

        set_wr_source(1'b0, '0);
        clear_logs();
        send_cmd(1'b0, 10, 1);
        wait_done("post_rst_rd", 50, 2);
        check_rd("post_rst_rd", 1, 16'h3000);

        // Zero-length and oversize commands
        clear_logs();
        send_cmd(1'b0, 7, 0);
`ifdef MEM_BURST_LEN_CHECK_EN
        for (int n = 0; n < 4; n++) clk_step();
        check("len0_err_count", err_cnt, 1);
        check("len0_err_latency", err_cyc - acc_cyc + 1, 1);
        check("len0_no_done", done_cnt, 0);
        check("len0_no_valid", valid_cnt, 0);
        check("len0_cmd_ready", bus.cmd_ready, 1);

        clear_logs();
        send_cmd(1'b0, 0, 65);
        for (int n = 0; n < 4; n++) clk_step();
        check("len65_err_count", err_cnt, 1);
        check("len65_no_done", done_cnt, 0);
        check("len65_no_valid", valid_cnt, 0);
`else
        wait_done("len0", 10, 1);
        check("len0_no_valid", valid_cnt, 0);

        clear_logs();
        send_cmd(1'b0, 63, 65);
        wait_done("len65", 300, 66);
        check_hs("len65", 63, 65, 1'b0, '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
